mem_access_unit: RTL

Load/store initiator for the MEM stage of the pipelined MIPS core. Accepts one memory operation at a time from the pipeline, drives the word-addressed data memory's `Address`/`WriteData`/`MemRead`/`MemWrite` pins, and extracts and extends sub-word load data. The data memory has no byte enables, so byte and halfword stores are performed as read-modify-write. Returns a single-cycle response to writeback and stalls the pipeline via `req_ready` while busy.

---
 rtl/mem_access_unit.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for the MEM stage of the pipelined MIPS core.
// Accepts one operation at a time, drives the word-addressed data memory and
// returns a single-cycle response. The memory has no byte enables, so byte and
// halfword stores are done as read-modify-write.
// All outputs are registered. MEM_LATENCY (1..15) is the number of cycles each
// memory phase holds its strobe.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with resp_err instead of aligning them down.
module mem_access_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_tag,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_tag,
  output logic        resp_err,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  // Operation captured at accept time.
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [1:0]  op_lane;
  logic [31:0] op_wdata;
  logic [4:0]  op_tag;

  // Request as seen at the accept edge, after size/alignment normalisation.
  logic [1:0]  acc_size;
  logic [1:0]  acc_lane;
  logic        acc_misalign;

  // Next values of the registered outputs.
  logic [31:0] address_nxt, write_data_nxt, resp_data_nxt;
  logic [4:0]  resp_tag_nxt;
  logic        mem_read_nxt, mem_write_nxt, resp_valid_nxt, resp_err_nxt;

  // Pick the addressed lane of a read word and sign/zero extend it.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  // Replace the target lane(s) of the old word with right-justified store data.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                        input logic [1:0] size, input logic [1:0] lane);
    merge = word;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    merge[7:0]   = data[7:0];
        2'd1:    merge[15:8]  = data[7:0];
        2'd2:    merge[23:16] = data[7:0];
        default: merge[31:24] = data[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (lane[1]) merge[31:16] = data[15:0];
      else         merge[15:0]  = data[15:0];
    end else begin
      merge = data;
    end
  endfunction

  // Normalise the incoming request: size 11 acts as a word, lane bits aligned per size.
  always_comb begin
    acc_size = (req_size == 2'b11) ? SZ_WORD : req_size;
    case (acc_size)
      SZ_BYTE: acc_lane = req_addr[1:0];
      SZ_HALF: acc_lane = {req_addr[1], 1'b0};
      default: acc_lane = 2'b00;
    endcase
`ifdef MISALIGN_TRAP_EN
    acc_misalign = ((acc_size == SZ_HALF) && req_addr[0]) ||
                   ((acc_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    acc_misalign = 1'b0;
`endif
  end

  // State and phase counter register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the operation on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_size     <= SZ_WORD;
      op_unsigned <= 1'b0;
      op_lane     <= 2'b00;
      op_wdata    <= '0;
      op_tag      <= '0;
    end else if ((state == IDLE) && req_valid) begin
      op_size     <= acc_size;
      op_unsigned <= req_unsigned;
      op_lane     <= acc_lane;
      op_wdata    <= req_wdata;
      op_tag      <= req_tag;
    end
  end

  // Next-state and next-output logic.
  // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    address_nxt    = '0;
    write_data_nxt = '0;
    mem_read_nxt   = 1'b0;
    mem_write_nxt  = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_data_nxt  = resp_data;
    resp_tag_nxt   = resp_tag;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_nxt = CNT_LOAD;
          if (acc_misalign) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_data_nxt  = '0;
            resp_tag_nxt   = req_tag;
          end else if (!req_store) begin
            state_nxt    = RD;
            mem_read_nxt = 1'b1;
            address_nxt  = {2'b00, req_addr[31:2]};
          end else if (acc_size == SZ_WORD) begin
            state_nxt      = WR;
            mem_write_nxt  = 1'b1;
            address_nxt    = {2'b00, req_addr[31:2]};
            write_data_nxt = req_wdata;
          end else begin
            state_nxt    = RMW_RD;
            mem_read_nxt = 1'b1;
            address_nxt  = {2'b00, req_addr[31:2]};
          end
        end
      end
      RD, RMW_RD: begin
        address_nxt = Address;
        if (cnt != 4'd0) begin
          cnt_nxt      = cnt - 4'd1;
          mem_read_nxt = 1'b1;
        end else if (state == RD) begin
          // Last read cycle: ReadData is driven now and is sampled at this edge.
          state_nxt      = RESP;
          address_nxt    = '0;
          resp_valid_nxt = 1'b1;
          resp_data_nxt  = extract(ReadData, op_size, op_lane, op_unsigned);
          resp_tag_nxt   = op_tag;
        end else begin
          state_nxt      = RMW_WR;
          cnt_nxt        = CNT_LOAD;
          mem_write_nxt  = 1'b1;
          write_data_nxt = merge(ReadData, op_wdata, op_size, op_lane);
        end
      end
      WR, RMW_WR: begin
        if (cnt != 4'd0) begin
          cnt_nxt        = cnt - 4'd1;
          mem_write_nxt  = 1'b1;
          address_nxt    = Address;
          write_data_nxt = WriteData;
        end else begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_data_nxt  = '0;
          resp_tag_nxt   = op_tag;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
      Address    <= '0;
      WriteData  <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
    end else begin
      req_ready  <= (state_nxt == IDLE);
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_data  <= resp_data_nxt;
      resp_tag   <= resp_tag_nxt;
      Address    <= address_nxt;
      WriteData  <= write_data_nxt;
      MemRead    <= mem_read_nxt;
      MemWrite   <= mem_write_nxt;
    end
  end

endmodule
